// File: rtl/instruction_memory_responder_if.sv
// Fetch-side bus of the instruction memory responder: request channel and response channel.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request (fetch) and response (instr) channels.
//
// Modports:
//   master - CPU fetch unit: drives request valid/address and response ready.
//   slave  - instruction memory responder: drives request ready and the response.
interface instruction_memory_responder_if #(
  parameter int XLEN = 32
);
  logic            i_Fetch_Valid;
  logic            o_Fetch_Ready;
  logic [XLEN-1:0] i_Fetch_Addr;
  logic            o_Instr_Valid;
  logic            i_Instr_Ready;
  logic [XLEN-1:0] o_Instruction;
  logic            o_Fetch_Fault;

  modport master (
    output i_Fetch_Valid, i_Fetch_Addr, i_Instr_Ready,
    input  o_Fetch_Ready, o_Instr_Valid, o_Instruction, o_Fetch_Fault
  );

  modport slave (
    input  i_Fetch_Valid, i_Fetch_Addr, i_Instr_Ready,
    output o_Fetch_Ready, o_Instr_Valid, o_Instruction, o_Fetch_Fault
  );
endinterface

// File: rtl/instruction_memory_responder.sv
// Instruction-fetch responder backed by MEMORY_DEPTH words of storage filled through a load port.
// Latency: accept at edge N -> response valid after edge N+1+WAIT_STATES; faults valid after edge N+1.
// Backpressure: response held stable until i_Instr_Ready; loads take priority over fetch acceptance.
//
// Ports:
//   i_Clock, i_Reset_N  - clock, synchronous active-low reset (storage is not cleared)
//   fetch_bus (slave)   - fetch request (valid/ready/addr) and response (valid/ready/instruction/fault)
//   i_Load_Enable, i_Load_Addr, i_Load_Data - program-load word write, any state, out-of-range dropped
//   o_Busy              - FSM not in IDLE
//
// Optional feature: define IMEM_BACK_TO_BACK_EN to accept the next fetch in the response
// handshake cycle, skipping IDLE between back-to-back fetches.
module instruction_memory_responder #(
  parameter int XLEN         = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int WAIT_STATES  = 1
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset_N,
  instruction_memory_responder_if.slave  fetch_bus,
  input  logic                           i_Load_Enable,
  input  logic [XLEN-1:0]                i_Load_Addr,
  input  logic [XLEN-1:0]                i_Load_Data,
  output logic                           o_Busy
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("instruction_memory_responder: WAIT_STATES must be in 0..15");
  end

  localparam int              AW          = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [XLEN-1:0] NOP         = XLEN'(32'h0000_0013);
  localparam logic [XLEN-3:0] DEPTH_WORDS = (XLEN-2)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [AW-1:0]   word_idx;
  logic            fault_q;
  logic            instr_vld_q;
  logic [XLEN-1:0] instr_dat_q;
  logic            fault_dat_q;

  logic [XLEN-1:0] mem [MEMORY_DEPTH];

  logic [XLEN-3:0] fetch_word;
  logic [XLEN-3:0] load_word;
  logic            fetch_fault;
  logic            can_accept;
  logic            fetch_fire;
  logic            unused_load_lsbs;

  assign fetch_word  = fetch_bus.i_Fetch_Addr[XLEN-1:2];
  assign load_word   = i_Load_Addr[XLEN-1:2];
  assign fetch_fault = (fetch_bus.i_Fetch_Addr[1:0] != 2'b00) || (fetch_word >= DEPTH_WORDS);

  // Load byte-offset bits carry no meaning for a word write.
  assign unused_load_lsbs = ^i_Load_Addr[1:0];

`ifdef IMEM_BACK_TO_BACK_EN
  // The response handshake frees the responder at the same edge, so a new fetch may start there.
  assign can_accept = (state == S_IDLE) || ((state == S_RESPOND) && fetch_bus.i_Instr_Ready);
`else
  assign can_accept = (state == S_IDLE);
`endif

  assign fetch_bus.o_Fetch_Ready = i_Reset_N && !i_Load_Enable && can_accept;
  assign fetch_fire              = fetch_bus.i_Fetch_Valid && fetch_bus.o_Fetch_Ready;

  assign fetch_bus.o_Instr_Valid = instr_vld_q;
  assign fetch_bus.o_Instruction = instr_dat_q;
  assign fetch_bus.o_Fetch_Fault = fault_dat_q;
  assign o_Busy                  = (state != S_IDLE);

  // Storage write. Reads below see the pre-edge contents, so a same-cycle load to the
  // word being read returns the old data.
  always_ff @(posedge i_Clock) begin
    if (i_Load_Enable && (load_word < DEPTH_WORDS)) begin
      mem[load_word[AW-1:0]] <= i_Load_Data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      word_idx    <= '0;
      fault_q     <= 1'b0;
      instr_vld_q <= 1'b0;
      instr_dat_q <= '0;
      fault_dat_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_WAIT: begin
          // A faulted fetch passes through WAIT with a zero count, giving it its one-cycle latency.
          if (wait_cnt == 4'd0) begin
            instr_vld_q <= 1'b1;
            instr_dat_q <= fault_q ? NOP : mem[word_idx];
            fault_dat_q <= fault_q;
            state       <= S_RESPOND;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          if (fetch_bus.i_Instr_Ready) begin
            instr_vld_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Acceptance only happens in IDLE or, with back-to-back enabled, at the response
      // handshake; placed last so it overrides the RESPOND -> IDLE transition.
      if (fetch_fire) begin
        state    <= S_WAIT;
        word_idx <= fetch_word[AW-1:0];
        fault_q  <= fetch_fault;
        wait_cnt <= fetch_fault ? 4'd0 : 4'(WAIT_STATES);
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench for instruction_memory_responder: directed fetch/load vectors with a
// scoreboard queue filled by the stimulus and drained by an independent response monitor.
// Inputs change on the falling edge; the monitor samples 2 time units after it.
module tb_instruction_memory_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;
`ifdef IMEM_BACK_TO_BACK_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int STREAM_PERIOD = WS + ((B2B != 0) ? 2 : 3);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        busy;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          vcyc;
  } exp_t;

  exp_t exp_q[$];
  int   resp_cyc[$];
  bit   in_resp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_memory_responder_if #(.XLEN(XLEN)) bus ();

  instruction_memory_responder #(
    .XLEN(XLEN),
    .MEMORY_DEPTH(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_N    (rst_n),
    .fetch_bus    (bus),
    .i_Load_Enable(load_en),
    .i_Load_Addr  (load_addr),
    .i_Load_Data  (load_data),
    .o_Busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Response monitor: checks start cycle on each new response, data on each handshake.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (bus.o_Instr_Valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        resp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_response: got instr 0x%08h with no fetch outstanding",
                   bus.o_Instruction);
        end else begin
          check("resp_cycle", cyc, exp_q[0].vcyc);
        end
      end
      if (bus.i_Instr_Ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_instr", bus.o_Instruction, e.instr);
          check("resp_fault", {31'd0, bus.o_Fetch_Fault}, {31'd0, e.fault});
        end
        in_resp = 1'b0;
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issues one fetch; returns at the falling edge after the accepting edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                       input logic exp_fault, input bit expect_resp);
    int budget = 50;
    @(negedge clk);
    bus.i_Fetch_Valid = 1'b1; bus.i_Fetch_Addr = addr;
    #1;
    while (!bus.o_Fetch_Ready && budget > 0) begin
      @(negedge clk); #1; budget--;
    end
    if (budget == 0) fail_now("fetch_accept");
    else if (expect_resp)
      exp_q.push_back('{exp_instr, exp_fault, cyc + 2 + (exp_fault ? 0 : WS)});
    @(negedge clk);
    bus.i_Fetch_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 100;
    do begin
      @(negedge clk); #3; budget--;
    end while ((exp_q.size() != 0 || busy) && budget > 0);
    if (budget == 0) fail_now("wait_idle");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int budget;
    bus.i_Fetch_Valid = 1'b1;
    bus.i_Fetch_Addr  = 32'h8;
    bus.i_Instr_Ready = 1'b1;

    // Reset held two cycles with a pending fetch.
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_fetch_ready", {31'd0, bus.o_Fetch_Ready}, 32'd0);
      check("rst_instr_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
      check("rst_instruction", bus.o_Instruction, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.i_Fetch_Valid = 1'b0;
    #1;
    check("idle_fetch_ready", {31'd0, bus.o_Fetch_Ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Program load, including an out-of-range write that must not alias onto word 0.
    load(32'h0000_0000, 32'hAAAA_0001);
    load(32'h0000_0004, 32'hBBBB_0002);
    load(32'h0000_0008, 32'h0050_0093);
    load(32'h0000_000C, 32'hC0DE_000C);
    load(32'h0000_0011, 32'h1234_0010);
    load(32'h0000_0FFC, 32'h7777_7FFC);
    load(32'h0000_1000, 32'hDEAD_BEEF);

    // Basic fetches and faults.
    fetch(32'h0000_0008, 32'h0050_0093, 1'b0, 1'b1); wait_idle();
    fetch(32'h0000_0006, NOP,           1'b1, 1'b1); wait_idle();
    fetch(32'h0000_1000, NOP,           1'b1, 1'b1); wait_idle();
    fetch(32'h0000_0002, NOP,           1'b1, 1'b1); wait_idle();
    fetch(32'hFFFF_FFFC, NOP,           1'b1, 1'b1); wait_idle();
    fetch(32'h0000_0FFC, 32'h7777_7FFC, 1'b0, 1'b1); wait_idle();
    fetch(32'h0000_0010, 32'h1234_0010, 1'b0, 1'b1); wait_idle();
    fetch(32'h0000_0000, 32'hAAAA_0001, 1'b0, 1'b1); wait_idle();

    // Backpressure: response must hold for 5 cycles, then IDLE after release.
    bus.i_Instr_Ready = 1'b0;
    fetch(32'h0000_0008, 32'h0050_0093, 1'b0, 1'b1);
    budget = 20;
    while (!bus.o_Instr_Valid && budget > 0) begin
      @(negedge clk); #2; budget--;
    end
    if (budget == 0) fail_now("bp_valid");
    repeat (5) begin
      @(negedge clk); #2;
      check("bp_valid", {31'd0, bus.o_Instr_Valid}, 32'd1);
      check("bp_instr", bus.o_Instruction, 32'h0050_0093);
      check("bp_fetch_ready", {31'd0, bus.o_Fetch_Ready}, 32'd0);
    end
    @(negedge clk);
    bus.i_Instr_Ready = 1'b1;
    @(negedge clk); #3;
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_ready", {31'd0, bus.o_Fetch_Ready}, 32'd1);

    // Load colliding with a fetch in IDLE: load wins that cycle, fetch accepted next.
    @(negedge clk);
    load_en = 1'b1; load_addr = 32'h14; load_data = 32'h5555_0014;
    bus.i_Fetch_Valid = 1'b1; bus.i_Fetch_Addr = 32'h14;
    #1;
    check("collide_ready", {31'd0, bus.o_Fetch_Ready}, 32'd0);
    @(negedge clk);
    load_en = 1'b0;
    #1;
    check("collide_next_ready", {31'd0, bus.o_Fetch_Ready}, 32'd1);
    exp_q.push_back('{32'h5555_0014, 1'b0, cyc + 2 + WS});
    @(negedge clk);
    bus.i_Fetch_Valid = 1'b0;
    wait_idle();

    // Load to the word on the very edge it is read: old data returned, new data afterwards.
    fetch(32'h0000_000C, 32'hC0DE_000C, 1'b0, 1'b1);
    repeat (WS) @(negedge clk);
    load_en = 1'b1; load_addr = 32'hC; load_data = 32'h0BAD_F00D;
    @(negedge clk);
    load_en = 1'b0;
    wait_idle();
    fetch(32'h0000_000C, 32'h0BAD_F00D, 1'b0, 1'b1); wait_idle();

    // Reset during WAIT: no response, next fetch unaffected.
    fetch(32'h0000_0008, 32'h0050_0093, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #2;
      check("abort_no_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
    end
    fetch(32'h0000_0004, 32'hBBBB_0002, 1'b0, 1'b1); wait_idle();

    // Streamed fetches with the consumer always ready.
    resp_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] data_tbl [3];
      data_tbl[0] = 32'hAAAA_0001; data_tbl[1] = 32'hBBBB_0002; data_tbl[2] = 32'h0050_0093;
      bus.i_Fetch_Valid = 1'b1; bus.i_Fetch_Addr = 32'(i * 4);
      #1;
      budget = 20;
      while (!bus.o_Fetch_Ready && budget > 0) begin
        @(negedge clk); #1; budget--;
      end
      if (budget == 0) fail_now("stream_accept");
      else exp_q.push_back('{data_tbl[i], 1'b0, cyc + 2 + WS});
      @(negedge clk);
    end
    bus.i_Fetch_Valid = 1'b0;
    wait_idle();
    check("stream_count", resp_cyc.size(), 32'd3);
    if (resp_cyc.size() == 3) begin
      check("stream_gap0", resp_cyc[1] - resp_cyc[0], STREAM_PERIOD);
      check("stream_gap1", resp_cyc[2] - resp_cyc[1], STREAM_PERIOD);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
